// File: rtl/vehicle_ctrl_hub_if.sv
// UART-side byte bus of vehicle_ctrl_hub: outgoing frame handshake and received detector bytes.
// The hub drives the master modport; the UART wrapper drives the slave modport.
interface vehicle_ctrl_hub_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output rx_valid,
        output rx_data
    );
endinterface

// File: rtl/vehicle_ctrl_hub.sv
// Mode arbitration, power/motion registers, UART frame packing and detector supervision.
// Optional periodic frame resend is compiled in when HUB_REFRESH_EN is defined.
module vehicle_ctrl_hub #(
    parameter int unsigned MODE_W      = 2,
    parameter int unsigned STATE_W     = 2,
    parameter int unsigned MOVE_W      = 4,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned STALE_CYC   = 1_000_000,
    parameter int unsigned REFRESH_CYC = 5_000_000,
    localparam int unsigned NModes     = 2 ** MODE_W
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [MODE_W-1:0]         global_state,
    input  logic                      power_on,
    input  logic                      power_off,
    input  logic [NModes*STATE_W-1:0] mode_next_state,
    input  logic [NModes*MOVE_W-1:0]  mode_next_moving,
    input  logic [NModes-1:0]         mode_power_kill,
    input  logic                      pl_beacon,
    input  logic                      de_beacon,
    vehicle_ctrl_hub_if.master        uart,
    output logic                      power,
    output logic [STATE_W-1:0]        state,
    output logic [MOVE_W-1:0]         moving_state,
    output logic [MODE_W-1:0]         active_mode,
    output logic                      settling,
    output logic [3:0]                detector,
    output logic                      detector_stale,
    output logic [2:0]                state_light,
    output logic [MOVE_W-1:0]         moving_light
);

    localparam int unsigned SettleW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned StaleW  = $clog2(STALE_CYC + 1);
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYC - 1);
    localparam logic [StaleW-1:0]  StaleMax   = StaleW'(STALE_CYC);

    typedef enum logic {PwrOff, PwrOn} pwr_e;
    typedef enum logic {StRun, StSettle} mode_e;

    pwr_e                pwr_q, pwr_d;
    mode_e               mode_q, mode_d;
    logic [SettleW-1:0]  settle_cnt_q, settle_cnt_d;
    logic [MODE_W-1:0]   active_mode_q, active_mode_d;
    logic [MODE_W-1:0]   gs_q;
    logic [STATE_W-1:0]  state_q;
    logic [MOVE_W-1:0]   moving_q;
    logic                state_load;
    logic [3:0]          det_q;
    logic [StaleW-1:0]   stale_cnt_q;
    logic [7:0]          frame, frame_prev_q;
    logic                refresh_tick, send_req;
    logic                tx_valid_q, tx_valid_d, dirty_q, dirty_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                unused_rx_hi;

    // ---------------- Power and mode FSMs: state registers ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pwr_q         <= PwrOff;
            mode_q        <= StRun;
            settle_cnt_q  <= '0;
            active_mode_q <= '0;
            gs_q          <= '0;
        end else begin
            pwr_q         <= pwr_d;
            mode_q        <= mode_d;
            settle_cnt_q  <= settle_cnt_d;
            active_mode_q <= active_mode_d;
            gs_q          <= global_state;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        pwr_d = pwr_q;
        case (pwr_q)
            PwrOff:  if (power_on && !power_off) pwr_d = PwrOn;
            PwrOn:   if (power_off || mode_power_kill[active_mode_q]) pwr_d = PwrOff;
            default: pwr_d = PwrOff;
        endcase
    end

    always_comb begin
        mode_d        = mode_q;
        settle_cnt_d  = settle_cnt_q;
        active_mode_d = active_mode_q;
        case (mode_q)
            StRun: begin
                if (global_state != active_mode_q) begin
                    mode_d       = StSettle;
                    settle_cnt_d = SettleLoad;
                end
            end
            StSettle: begin
                // A request that moves again restarts the whole forced-stop window.
                if (global_state != gs_q) begin
                    settle_cnt_d = SettleLoad;
                end else if (settle_cnt_q == '0) begin
                    active_mode_d = global_state;
                    mode_d        = StRun;
                end else begin
                    settle_cnt_d = settle_cnt_q - SettleW'(1);
                end
            end
            default: mode_d = StRun;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        power    = (pwr_q == PwrOn);
        settling = (mode_q == StSettle);
    end

    // Slices load only across RUN->RUN so the new mode appears one cycle after active_mode.
    assign state_load = (pwr_d == PwrOn) && (mode_q == StRun) && (mode_d == StRun);

    always_ff @(posedge sys_clk) begin
        if (rst || !state_load) begin
            state_q  <= '0;
            moving_q <= '0;
        end else begin
            state_q  <= mode_next_state[int'(active_mode_q) * STATE_W +: STATE_W];
            moving_q <= mode_next_moving[int'(active_mode_q) * MOVE_W +: MOVE_W];
        end
    end

    assign state        = state_q;
    assign moving_state = moving_q;
    assign moving_light = moving_q;
    assign active_mode  = active_mode_q;

    always_comb begin
        state_light = 3'b000;
        if (power) begin
            if (state_q == STATE_W'(0))      state_light = 3'b001;
            else if (state_q == STATE_W'(1)) state_light = 3'b010;
            else if (state_q == STATE_W'(2)) state_light = 3'b100;
            else if (state_q == STATE_W'(3)) state_light = 3'b111;
        end
    end

    // ---------------- Detector latch with staleness supervision ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            det_q       <= 4'hF;
            stale_cnt_q <= StaleMax;
        end else if (uart.rx_valid) begin
            det_q       <= uart.rx_data[3:0];
            stale_cnt_q <= '0;
        end else if (stale_cnt_q != StaleMax) begin
            stale_cnt_q <= stale_cnt_q + StaleW'(1);
        end
    end

    assign detector_stale = (stale_cnt_q == StaleMax);
    assign detector       = detector_stale ? 4'hF : det_q;
    assign unused_rx_hi   = ^uart.rx_data[7:4];

    // ---------------- Refresh tick ----------------
`ifdef HUB_REFRESH_EN
    localparam int unsigned RefW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    logic [RefW-1:0] ref_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (rst || refresh_tick) ref_cnt_q <= '0;
        else                     ref_cnt_q <= ref_cnt_q + RefW'(1);
    end

    assign refresh_tick = (ref_cnt_q == RefW'(REFRESH_CYC - 1));
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = (REFRESH_CYC == 0);
    assign refresh_tick       = 1'b0;
`endif

    // ---------------- TX frame handshake ----------------
    assign frame    = {2'b10, de_beacon, pl_beacon, moving_q[3:0]};
    assign send_req = (frame != frame_prev_q) || refresh_tick;

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        dirty_d    = dirty_q;
        if (tx_valid_q) begin
            if (uart.tx_ready) begin
                // Back-to-back: a queued update is loaded on the completing edge.
                if (send_req || dirty_q) tx_data_d = frame;
                else                     tx_valid_d = 1'b0;
                dirty_d = 1'b0;
            end else if (send_req) begin
                dirty_d = 1'b1;
            end
        end else if (send_req || dirty_q) begin
            tx_data_d  = frame;
            tx_valid_d = 1'b1;
            dirty_d    = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h80;
            dirty_q      <= 1'b0;
            frame_prev_q <= 8'h80;
        end else begin
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            dirty_q      <= dirty_d;
            frame_prev_q <= frame;
        end
    end

    assign uart.tx_valid = tx_valid_q;
    assign uart.tx_data  = tx_data_q;

endmodule

// File: tb/tb_vehicle_ctrl_hub.sv
// Directed plus randomized bench for vehicle_ctrl_hub against a cycle-level behavioural model.
module tb_vehicle_ctrl_hub;
    localparam int SETTLE  = 4;
    localparam int STALE   = 8;
    localparam int REFRESH = 32;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  global_state = '0;
    logic        power_on = 1'b0, power_off = 1'b0;
    logic [7:0]  mode_next_state = '0;
    logic [15:0] mode_next_moving = '0;
    logic [3:0]  mode_power_kill = '0;
    logic        pl_beacon = 1'b0, de_beacon = 1'b0;
    logic        power, settling, detector_stale;
    logic [1:0]  state, active_mode;
    logic [3:0]  moving_state, detector, moving_light;
    logic [2:0]  state_light;

    vehicle_ctrl_hub_if bus ();

    vehicle_ctrl_hub #(
        .MODE_W(2), .STATE_W(2), .MOVE_W(4),
        .SETTLE_CYC(SETTLE), .STALE_CYC(STALE), .REFRESH_CYC(REFRESH)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .global_state(global_state),
        .power_on(power_on), .power_off(power_off),
        .mode_next_state(mode_next_state), .mode_next_moving(mode_next_moving),
        .mode_power_kill(mode_power_kill), .pl_beacon(pl_beacon), .de_beacon(de_beacon),
        .uart(bus), .power(power), .state(state), .moving_state(moving_state),
        .active_mode(active_mode), .settling(settling), .detector(detector),
        .detector_stale(detector_stale), .state_light(state_light), .moving_light(moving_light)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;

    // Model: m_rem counts settle cycles still to go (0 = running).
    bit m_pwr, m_txv, m_dirty;
    int m_act, m_rem, m_gs_prev, m_st, m_mv, m_det, m_since, m_txd, m_fprev, m_ref;

    task automatic model_reset();
        m_pwr = 0; m_act = 0; m_rem = 0; m_gs_prev = 0; m_st = 0; m_mv = 0;
        m_det = 15; m_since = STALE; m_txv = 0; m_txd = 'h80; m_dirty = 0;
        m_fprev = 'h80; m_ref = 0;
    endtask

    function automatic int light(bit p, int s);
        if (!p) return 0;
        case (s)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 7;
        endcase
    endfunction

    task automatic model_step();
        bit n_pwr, tick, req;
        int n_act, n_rem, gs, frame;
        gs = int'(global_state);
        n_pwr = m_pwr;
        if (!m_pwr && power_on && !power_off) n_pwr = 1;
        if (m_pwr && (power_off || mode_power_kill[m_act])) n_pwr = 0;
        n_act = m_act;
        n_rem = m_rem;
        if (m_rem == 0) begin
            if (gs != m_act) n_rem = SETTLE;
        end else if (gs != m_gs_prev) begin
            n_rem = SETTLE;
        end else begin
            n_rem = m_rem - 1;
            if (n_rem == 0) n_act = gs;
        end
        frame = 'h80 + (int'(de_beacon) << 5) + (int'(pl_beacon) << 4) + m_mv;
        tick = 0;
`ifdef HUB_REFRESH_EN
        tick = (m_ref == REFRESH - 1);
        m_ref = (m_ref + 1) % REFRESH;
`endif
        req = (frame != m_fprev) || tick;
        if (m_txv) begin
            if (bus.tx_ready) begin
                if (req || m_dirty) m_txd = frame;
                else m_txv = 0;
                m_dirty = 0;
            end else if (req) begin
                m_dirty = 1;
            end
        end else if (req || m_dirty) begin
            m_txd = frame; m_txv = 1; m_dirty = 0;
        end
        m_fprev = frame;
        if (n_pwr && m_rem == 0 && n_rem == 0) begin
            m_st = int'(mode_next_state >> (2 * m_act)) & 3;
            m_mv = int'(mode_next_moving >> (4 * m_act)) & 15;
        end else begin
            m_st = 0; m_mv = 0;
        end
        if (bus.rx_valid) begin
            m_det = int'(bus.rx_data) & 15; m_since = 0;
        end else if (m_since < STALE) begin
            m_since++;
        end
        m_pwr = n_pwr; m_act = n_act; m_rem = n_rem; m_gs_prev = gs;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("power", 32'(power), 32'(m_pwr));
        chk("state", 32'(state), 32'(m_st));
        chk("moving_state", 32'(moving_state), 32'(m_mv));
        chk("active_mode", 32'(active_mode), 32'(m_act));
        chk("settling", 32'(settling), 32'(m_rem != 0));
        chk("detector_stale", 32'(detector_stale), 32'(m_since == STALE));
        chk("detector", 32'(detector), (m_since == STALE) ? 32'd15 : 32'(m_det));
        chk("state_light", 32'(state_light), 32'(light(m_pwr, m_st)));
        chk("moving_light", 32'(moving_light), 32'(m_mv));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        chk("tx_data", 32'(bus.tx_data), 32'(m_txd));
    endtask

    task automatic cyc();
        model_step();
        @(posedge sys_clk);
        #1;
        check_all();
    endtask

    initial begin
        bit found;
        int pulses;
        bus.tx_ready = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        model_reset();
        rst = 1'b0;
        check_all();
        chk("rst_tx_data", 32'(bus.tx_data), 32'h80);
        chk("rst_stale", 32'(detector_stale), 32'd1);

        // Power on with mode 0 reporting state 1.
        mode_next_state = 8'h01;
        power_on = 1'b1;
        cyc();
        power_on = 1'b0;
        chk("pwr_on", 32'(power), 32'd1);
        cyc();
        chk("light_s1", 32'(state_light), 32'b010);

        // Simultaneous on/off: off wins and outputs clear in one cycle.
        mode_next_state = 8'h02;
        mode_next_moving = 16'h0005;
        cyc(); cyc();
        power_on = 1'b1; power_off = 1'b1;
        cyc();
        power_on = 1'b0; power_off = 1'b0;
        chk("off_pwr", 32'(power), 32'd0);
        chk("off_state", 32'(state), 32'd0);
        chk("off_moving", 32'(moving_state), 32'd0);
        chk("off_light", 32'(state_light), 32'd0);

        // Mode switch 0->1 with forced-stop window, then restart mid-settle.
        power_on = 1'b1;
        cyc();
        power_on = 1'b0;
        mode_next_state = 8'h0E;
        mode_next_moving = 16'h0035;
        global_state = 2'd1;
        cyc();
        chk("settle_rise", 32'(settling), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("settle_hold", 32'(settling), 32'd1);
            chk("settle_state0", 32'(state), 32'd0);
        end
        cyc();
        chk("settle_done", 32'(settling), 32'd0);
        chk("active_1", 32'(active_mode), 32'd1);
        cyc();
        chk("slice1_state", 32'(state), 32'd3);
        global_state = 2'd2;
        cyc(); cyc();
        global_state = 2'd3;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("restart_hold", 32'(settling), 32'd1);
        end
        cyc();
        chk("restart_done", 32'(settling), 32'd0);
        chk("active_3", 32'(active_mode), 32'd3);

        // TX stall with an update queued behind it.
        repeat (4) cyc();
        mode_next_moving = 16'h8035;
        bus.tx_ready = 1'b0;
        cyc(); cyc();
        chk("tx_first_valid", 32'(bus.tx_valid), 32'd1);
        chk("tx_first_data", 32'(bus.tx_data), 32'h88);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) mode_next_moving = 16'h4035;
            cyc();
            chk("tx_hold", 32'(bus.tx_data), 32'h88);
        end
        bus.tx_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            cyc();
            if (bus.tx_valid && bus.tx_data == 8'h84) found = 1;
        end
        chk("tx_resend_84", 32'(found), 32'd1);

        // Detector byte then staleness.
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h05;
        cyc();
        bus.rx_valid = 1'b0;
        chk("det_5", 32'(detector), 32'h5);
        chk("det_fresh", 32'(detector_stale), 32'd0);
        repeat (STALE - 1) cyc();
        chk("det_not_yet", 32'(detector_stale), 32'd0);
        cyc();
        chk("det_stale", 32'(detector_stale), 32'd1);
        chk("det_blocked", 32'(detector), 32'hF);

        // Static frame: pulses only from the refresh tick.
        power_off = 1'b1;
        cyc();
        power_off = 1'b0;
        repeat (8) cyc();
        pulses = 0;
        for (int i = 0; i < 2 * REFRESH; i++) begin
            cyc();
            if (bus.tx_valid) pulses++;
        end
`ifdef HUB_REFRESH_EN
        chk("refresh_pulses", 32'(pulses), 32'd2);
`else
        chk("refresh_pulses", 32'(pulses), 32'd0);
`endif

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(11) == 0) global_state = 2'($urandom);
            power_on = ($urandom_range(5) == 0);
            power_off = ($urandom_range(19) == 0);
            mode_power_kill = ($urandom_range(39) == 0) ? 4'($urandom) : 4'h0;
            mode_next_state = 8'($urandom);
            if ($urandom_range(3) == 0) mode_next_moving = 16'($urandom);
            if ($urandom_range(9) == 0) pl_beacon = ~pl_beacon;
            if ($urandom_range(9) == 0) de_beacon = ~de_beacon;
            bus.rx_valid = ($urandom_range(4) == 0);
            bus.rx_data = 8'($urandom);
            bus.tx_ready = 1'($urandom);
            if (i == 200) begin
                rst = 1'b1;
                @(posedge sys_clk);
                #1;
                rst = 1'b0;
                model_reset();
                check_all();
            end else begin
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vehicle_ctrl_hub.md
# vehicle_ctrl_hub

Parametrised control hub for the simulated car. It arbitrates between N driving-mode engines (manual, semi-auto, auto, …), owns the registered power / motion-state / turn-state registers, and enforces a forced-stop settle window on every mode change. It also packs the motion and beacon frame for the UART transmitter through a valid/ready handshake, and latches detector bytes from the UART receiver with staleness supervision. It replaces the combinational mode mux in the device top and sits between the mode engines and `uart_top`.

## Interface

Parameters:
- `MODE_W`, 2: mode select width; N_MODES = 2**MODE_W.
- `STATE_W`, 2: motion-state width.
- `MOVE_W`, 4: turn/moving-state width; must be ≥ 4.
- `SETTLE_CYC`, 16: forced-stop cycles on mode change; must be ≥ 1.
- `STALE_CYC`, 1_000_000: cycles without a detector byte before the detectors are declared stale.
- `REFRESH_CYC`, 5_000_000: periodic frame resend interval; used only under `HUB_REFRESH_EN`.

Ports:
- `sys_clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `global_state` in MODE_W: requested mode.
- `power_on`, `power_off` in 1: power requests, level-sensitive.
- `mode_next_state` in N_MODES*STATE_W: per-mode next state; mode k occupies bits [k*STATE_W +: STATE_W].
- `mode_next_moving` in N_MODES*MOVE_W: per-mode next moving state, packed the same way.
- `mode_power_kill` in N_MODES: per-mode power-off request, for example a manual stall.
- `pl_beacon`, `de_beacon` in 1: beacon place / destroy flags.
- `rx_valid` in 1, `rx_data` in 8: received detector byte.
- `tx_ready` in 1: UART transmitter can accept a byte.
- `tx_valid` out 1, `tx_data` out 8: outgoing frame.
- `power` out 1.
- `state` out STATE_W.
- `moving_state` out MOVE_W.
- `active_mode` out MODE_W.
- `settling` out 1.
- `detector` out 4: {back, right, left, front}.
- `detector_stale` out 1.
- `state_light` out 3.
- `moving_light` out MOVE_W.

## Operation

- **Power FSM (OFF, ON).**
  - OFF→ON when `power_on` && !`power_off`.
  - ON→OFF when `power_off` or `mode_power_kill[active_mode]`.
  - If on and off are asserted together, off wins.
- **Mode FSM (RUN, SETTLE).**
  - RUN with `global_state` ≠ `active_mode`: go to SETTLE and load the counter with SETTLE_CYC-1.
  - SETTLE: the counter decrements each cycle. Any change of `global_state` reloads the counter.
  - At count 0: `active_mode` ← `global_state`, go to RUN.
  - `settling` = (mode FSM is in SETTLE).
- **State registers.**
  - When power is ON and the mode FSM is in RUN: `state` and `moving_state` load the `active_mode` slices of `mode_next_state` and `mode_next_moving`.
  - In SETTLE or OFF: both are forced to 0.
- **Lights** (combinational decode of registered outputs).
  - `state_light`:
    - power off → 000
    - state 0 → 001
    - state 1 → 010
    - state 2 → 100
    - state 3 → 111
  - `moving_light` = `moving_state`.
- **Detectors.**
  - On `rx_valid`: `detector` ← `rx_data[3:0]` and the stale counter clears.
  - Otherwise the stale counter increments and saturates at STALE_CYC.
  - `detector_stale` = (counter == STALE_CYC). While stale, `detector` reads 4'b1111 (all blocked).
- **TX frame** = {2'b10, `de_beacon`, `pl_beacon`, `moving_state[3:0]`}.
  - Frame change or refresh tick with no transfer pending: capture the frame into `tx_data` and assert `tx_valid`.
  - `tx_data` is held stable while `tx_valid` is high.
  - A transfer completes on `tx_valid` && `tx_ready`.
  - A frame change while a transfer is pending sets `dirty`. After the handshake, `tx_valid` reasserts on the next cycle with the latest frame.
  - Identical consecutive frames are not resent, except on a refresh tick.

## Timing

- Reset values:
  - `power` 0, `state` 0, `moving_state` 0.
  - `active_mode` 0, mode FSM RUN, `settling` 0.
  - `detector` 4'b1111, `detector_stale` 1 (counter = STALE_CYC).
  - `tx_valid` 0, `tx_data` 8'h80, `dirty` 0.
  - `state_light` 000, `moving_light` 0.
- Reset mid-SETTLE or mid-transfer aborts immediately. The pending frame is dropped.
- Mode slice → `state`: 1 cycle.
- `power_off` → `power`=0 and state/moving=0: 1 cycle.
- Mode change: `settling` rises 1 cycle after the `global_state` change. `active_mode` updates SETTLE_CYC cycles after that. The new mode's slice appears 1 cycle later.
- Frame change → `tx_valid`: 1 cycle.
- `rx_valid` → `detector`: 1 cycle. After the last `rx_valid`, `detector_stale` asserts STALE_CYC cycles later.
- A power change in the same cycle as a mode change: both FSMs advance independently.

## Configuration

- `HUB_REFRESH_EN` defined:
  - A free-running counter issues a refresh tick every REFRESH_CYC cycles.
  - Each tick requests a send of the current frame even if unchanged; if a transfer is pending it sets `dirty`.
  - The counter resets to 0.
- Not defined: frames are sent only on change. No refresh counter is synthesised and `REFRESH_CYC` is ignored.

## Test plan

Bench parameters: SETTLE_CYC=4, STALE_CYC=8, REFRESH_CYC=32.

- Reset, then 1-cycle `power_on` → `power`=1 next cycle. With `state` 1 selected, `state_light` shows 010.
- Power on, mode 0 slice {state 2, moving 4'b0101}, `power_off`+`power_on` together → `power`=0, `state`=0, `moving_state`=0, `state_light`=000.
- Switch `global_state` 0→1 → `settling`=1 for 4 cycles with outputs 0. Then `active_mode`=1 and `state` follows slice 1. A second switch mid-settle restarts the 4-cycle window.
- `moving_state` 0→4'b1000 with `tx_ready`=0 for 5 cycles → `tx_data`=8'h88 held, `tx_valid` high. A change to 4'b0100 during the stall → after the handshake, `tx_valid` reasserts with 8'h84.
- `rx_valid` with 8'h05 → `detector`=0101, `detector_stale`=0. No further bytes for 8 cycles → `stale`=1, `detector`=1111.
- `HUB_REFRESH_EN`, static frame 8'h80, `tx_ready`=1 → exactly one `tx_valid` pulse every 32 cycles. Without the macro → no pulses.
